// File: rtl/cnt_gate_pkg.sv
// Shared types and constants for the multi-channel count-gate controller.
package cnt_gate_pkg;

    localparam int ST_W = 2;

    // Encodings are visible on s_out and must stay fixed.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'b10,
        ST_ARM  = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b11
    } state_t;

    function automatic logic st_is_wait(input state_t st);
        logic res;
        case (st)
            ST_ARM:  res = 1'b1;
            ST_HOLD: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cnt_gate_ch.sv
// One count-gate channel: optional input synchroniser, qualify/release FSM, delay timer, event tally.
// Optional feature: CNT_GATE_SYNC_EN adds a 2-flop synchroniser on count (+2 cycles latency).
module cnt_gate_ch
    import cnt_gate_pkg::*;
#(
    parameter int DLY_W = 21,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count,
    input  logic             mode,
    input  logic [DLY_W-1:0] dly_lim,
    input  logic             clr,
    output logic             cnt,
    output logic [EVT_W-1:0] evt,
    output logic [ST_W-1:0]  state
);

    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_ZERO = {EVT_W{1'b0}};
    localparam logic [EVT_W-1:0] EVT_ONE  = {{(EVT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};

    // Clear wins first, so clear plus increment on one edge leaves a count of one.
    function automatic logic [EVT_W-1:0] evt_update(
        input logic [EVT_W-1:0] cur,
        input logic             inc,
        input logic             clear
    );
        logic [EVT_W-1:0] res;
        if (clear) begin
            res = inc ? EVT_ONE : EVT_ZERO;
        end else if (inc && (cur != EVT_MAX)) begin
            res = cur + EVT_ONE;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic             count_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [DLY_W-1:0] dly_r;
    logic [DLY_W-1:0] dly_nxt_s;
    logic             dly_ovf_s;
    logic             evt_inc_s;
    logic [EVT_W-1:0] evt_r;
    logic [EVT_W-1:0] evt_nxt_s;
    logic             cnt_r;
    logic             cnt_nxt_s;

`ifdef CNT_GATE_SYNC_EN
    logic [1:0] sync_r;

    // Two-stage synchroniser for the asynchronous request level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], count};
        end
    end

    assign count_s = sync_r[1];
`else
    assign count_s = count;
`endif

    // >= rather than == so a lowered limit mid-wait can never strand the channel.
    assign dly_ovf_s = (dly_r >= dly_lim);

    // Next-state selection; request level takes priority over timer expiry.
    always_comb begin
        state_nxt_s = state_r;
        evt_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!count_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (dly_ovf_s) begin
                    state_nxt_s = ST_RUN;
                    evt_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_RUN: begin
                if (!count_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (count_s) begin
                    state_nxt_s = ST_RUN;
                end else if (dly_ovf_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Delay timer, gate level and event tally for the upcoming cycle.
    always_comb begin
        dly_nxt_s = DLY_ZERO;
        cnt_nxt_s = 1'b0;
        if (state_nxt_s != state_r) begin
            dly_nxt_s = DLY_ZERO;
        end else if (st_is_wait(state_r)) begin
            dly_nxt_s = dly_r + DLY_ONE;
        end else begin
            dly_nxt_s = DLY_ZERO;
        end
        // Pulse mode only fires on the ARM->RUN entry, never on HOLD->RUN.
        case (state_nxt_s)
            ST_RUN:  cnt_nxt_s = mode ? (state_r == ST_ARM) : 1'b1;
            ST_HOLD: cnt_nxt_s = ~mode;
            default: cnt_nxt_s = 1'b0;
        endcase
        evt_nxt_s = evt_update(evt_r, evt_inc_s, clr);
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            dly_r   <= DLY_ZERO;
            evt_r   <= EVT_ZERO;
            cnt_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            dly_r   <= dly_nxt_s;
            evt_r   <= evt_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign cnt   = cnt_r;
    assign evt   = evt_r;
    assign state = state_r;

endmodule

// File: rtl/cnt_gate_ctrl.sv
// Multi-channel debounced count-gate controller; one independent cnt_gate_ch per channel.
// Optional feature: CNT_GATE_SYNC_EN (input synchroniser inside each channel).
module cnt_gate_ctrl
    import cnt_gate_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DLY_W  = 21,
    parameter int EVT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       count,
    input  logic                    mode,
    input  logic [DLY_W-1:0]        dly_lim,
    input  logic                    clr,
    output logic [NUM_CH-1:0]       cnt,
    output logic [NUM_CH*EVT_W-1:0] evt,
    output logic [ST_W*NUM_CH-1:0]  s_out
);

    // Global controls fan out unchanged; there is no cross-channel interaction.
    for (genvar ch_g = 0; ch_g < NUM_CH; ch_g++) begin : g_ch
        cnt_gate_ch #(
            .DLY_W (DLY_W),
            .EVT_W (EVT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .count   (count[ch_g]),
            .mode    (mode),
            .dly_lim (dly_lim),
            .clr     (clr),
            .cnt     (cnt[ch_g]),
            .evt     (evt[ch_g*EVT_W +: EVT_W]),
            .state   (s_out[ch_g*ST_W +: ST_W])
        );
    end

endmodule
